// File: rtl/usb_line_monitor_pkg.sv
// rtl/usb_line_monitor_pkg.sv - USB line-state and link-state types shared with the device core
package usb_line_monitor_pkg;

  typedef enum logic [1:0] {
    DP_SE0 = 2'b00,
    DP_J   = 2'b01,
    DP_K   = 2'b10,
    DP_SE1 = 2'b11
  } d_port_t;

  typedef enum logic [1:0] {
    LS_ACTIVE    = 2'b00,
    LS_BUS_RESET = 2'b01,
    LS_SUSPENDED = 2'b10
  } usb_link_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_run_counter.sv
// rtl/usb_run_counter.sv - saturating run-length counter over consecutive identical line states
module usb_run_counter
  import usb_line_monitor_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_ni,
  input  d_port_t          line_state,
  output logic [CNT_W-1:0] run_next,
  output logic [CNT_W-1:0] run
);

  localparam logic [CNT_W-1:0] RUN_MAX = '1;

  d_port_t          r_ls_q;
  logic [CNT_W-1:0] r_run;

  // Saturation keeps a long run from wrapping back through a threshold.
  always_comb begin
    if (line_state != r_ls_q) begin
      run_next = CNT_W'(1);
    end else if (r_run == RUN_MAX) begin
      run_next = RUN_MAX;
    end else begin
      run_next = r_run + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ls_q <= DP_J;
      r_run  <= '0;
    end else begin
      r_ls_q <= line_state;
      r_run  <= run_next;
    end
  end

  assign run = r_run;

endmodule

// File: rtl/usb_line_monitor.sv
// rtl/usb_line_monitor.sv - bus reset / suspend / resume link-state monitor
// USB_LINE_MONITOR_RESUME_EN: timed K-run resume with resume_o pulse; otherwise any K/SE1 wakes.
module usb_line_monitor
  import usb_line_monitor_pkg::*;
#(
  parameter int RESET_CYCLES   = 60,
  parameter int SUSPEND_CYCLES = 72000,
  parameter int RESUME_CYCLES  = 240
) (
  input  logic    clk,
  input  logic    reset_ni,
  input  d_port_t line_state,
  output logic    reset_o,
  output logic    bus_reset_o,
  output logic    suspend_o,
  output logic    resume_o
);

  localparam int CNT_W = $clog2(max3(RESET_CYCLES, SUSPEND_CYCLES, RESUME_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RESET_THR   = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] SUSPEND_THR = CNT_W'(SUSPEND_CYCLES);
`ifdef USB_LINE_MONITOR_RESUME_EN
  localparam logic [CNT_W-1:0] RESUME_THR  = CNT_W'(RESUME_CYCLES);
`endif

  logic [CNT_W-1:0] w_run_next;
  logic [CNT_W-1:0] w_run_unused;
  logic             w_se0_hit;
  logic             w_reset_evt;
  usb_link_state_t  w_state_next;
  usb_link_state_t  r_state;
  logic             r_reset;
  logic             r_bus_reset;
  logic             r_suspend;
`ifdef USB_LINE_MONITOR_RESUME_EN
  logic             w_resume_evt;
  logic             r_resume;
`endif

  usb_run_counter #(
    .CNT_W(CNT_W)
  ) u_run_counter (
    .clk       (clk),
    .reset_ni  (reset_ni),
    .line_state(line_state),
    .run_next  (w_run_next),
    .run       (w_run_unused)
  );

  assign w_se0_hit = (line_state == DP_SE0) && (w_run_next == RESET_THR);

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= LS_ACTIVE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Each event moves to a state where the same run cannot re-fire it.
  always_comb begin
    w_state_next = r_state;
    w_reset_evt  = 1'b0;
`ifdef USB_LINE_MONITOR_RESUME_EN
    w_resume_evt = 1'b0;
`endif
    case (r_state)
      LS_ACTIVE: begin
        if (w_se0_hit) begin
          w_state_next = LS_BUS_RESET;
          w_reset_evt  = 1'b1;
        end else if ((line_state == DP_J) && (w_run_next == SUSPEND_THR)) begin
          w_state_next = LS_SUSPENDED;
        end
      end
      LS_BUS_RESET: begin
        if (line_state != DP_SE0) begin
          w_state_next = LS_ACTIVE;
        end
      end
      LS_SUSPENDED: begin
        if (w_se0_hit) begin
          w_state_next = LS_BUS_RESET;
          w_reset_evt  = 1'b1;
`ifdef USB_LINE_MONITOR_RESUME_EN
        end else if ((line_state == DP_K) && (w_run_next == RESUME_THR)) begin
          w_state_next = LS_ACTIVE;
          w_resume_evt = 1'b1;
`else
        end else if ((line_state == DP_K) || (line_state == DP_SE1)) begin
          w_state_next = LS_ACTIVE;
`endif
        end
      end
      default: w_state_next = LS_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_reset     <= 1'b0;
      r_bus_reset <= 1'b0;
      r_suspend   <= 1'b0;
`ifdef USB_LINE_MONITOR_RESUME_EN
      r_resume    <= 1'b0;
`endif
    end else begin
      r_reset     <= w_reset_evt;
      r_bus_reset <= (w_state_next == LS_BUS_RESET);
      r_suspend   <= (w_state_next == LS_SUSPENDED);
`ifdef USB_LINE_MONITOR_RESUME_EN
      r_resume    <= w_resume_evt;
`endif
    end
  end

  assign reset_o     = r_reset;
  assign bus_reset_o = r_bus_reset;
  assign suspend_o   = r_suspend;
`ifdef USB_LINE_MONITOR_RESUME_EN
  assign resume_o    = r_resume;
`else
  assign resume_o    = 1'b0;
`endif

endmodule

// File: tb/tb_usb_line_monitor.sv
// tb/tb_usb_line_monitor.sv - directed-vector bench for usb_line_monitor with shortened thresholds
module tb_usb_line_monitor;
  import usb_line_monitor_pkg::*;

  localparam int RST_N = 6;
  localparam int SUS_N = 40;
  localparam int RES_N = 10;

  logic    clk;
  logic    reset_ni;
  d_port_t line_state;
  logic    reset_o;
  logic    bus_reset_o;
  logic    suspend_o;
  logic    resume_o;

  int n_vec;
  int n_err;

  usb_line_monitor #(
    .RESET_CYCLES  (RST_N),
    .SUSPEND_CYCLES(SUS_N),
    .RESUME_CYCLES (RES_N)
  ) dut (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .line_state (line_state),
    .reset_o    (reset_o),
    .bus_reset_o(bus_reset_o),
    .suspend_o  (suspend_o),
    .resume_o   (resume_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input d_port_t ls);
    line_state = ls;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_ni   = 1'b0;
    line_state = DP_SE0;
    repeat (3) @(posedge clk);
    #1;
    if ({reset_o, bus_reset_o, suspend_o, resume_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0000", {reset_o, bus_reset_o, suspend_o, resume_o});
    end
    n_vec++;
    line_state = DP_J;
    reset_ni   = 1'b1;
  endtask

  task automatic test_bus_reset;
    for (int i = 1; i < RST_N; i++) begin
      tick(DP_SE0);
      if ({reset_o, bus_reset_o} !== 2'b00) begin
        n_err++;
        $display("FAIL short_se0 sample %0d: got %b expected 00", i, {reset_o, bus_reset_o});
      end
      n_vec++;
    end
    tick(DP_J);
    for (int i = 1; i <= RST_N + 3; i++) begin
      tick(DP_SE0);
      if (reset_o !== (i == RST_N)) begin
        n_err++;
        $display("FAIL reset_pulse sample %0d: got %b expected %b", i, reset_o, (i == RST_N));
      end
      n_vec++;
      if (bus_reset_o !== (i >= RST_N)) begin
        n_err++;
        $display("FAIL bus_reset_level sample %0d: got %b expected %b", i, bus_reset_o, (i >= RST_N));
      end
      n_vec++;
    end
    tick(DP_J);
    if ({reset_o, bus_reset_o} !== 2'b00) begin
      n_err++;
      $display("FAIL bus_reset_exit: got %b expected 00", {reset_o, bus_reset_o});
    end
    n_vec++;
  endtask

  task automatic test_se1;
    for (int i = 0; i < RST_N - 1; i++) tick(DP_SE0);
    tick(DP_SE1);
    for (int i = 1; i <= RST_N; i++) begin
      tick(DP_SE0);
      if (reset_o !== (i == RST_N)) begin
        n_err++;
        $display("FAIL se1_restart sample %0d: got %b expected %b", i, reset_o, (i == RST_N));
      end
      n_vec++;
    end
    tick(DP_J);
  endtask

  task automatic test_suspend;
    tick(DP_K);
    for (int i = 1; i < SUS_N; i++) tick(DP_J);
    if (suspend_o !== 1'b0) begin
      n_err++;
      $display("FAIL suspend_early: got %b expected 0", suspend_o);
    end
    n_vec++;
    tick(DP_K);
    for (int i = 1; i <= SUS_N; i++) begin
      tick(DP_J);
      if (suspend_o !== (i == SUS_N)) begin
        n_err++;
        $display("FAIL suspend_rise sample %0d: got %b expected %b", i, suspend_o, (i == SUS_N));
      end
      n_vec++;
    end
    tick(DP_J);
    if (suspend_o !== 1'b1) begin
      n_err++;
      $display("FAIL suspend_hold: got %b expected 1", suspend_o);
    end
    n_vec++;
  endtask

  task automatic test_resume;
`ifdef USB_LINE_MONITOR_RESUME_EN
    for (int i = 1; i < RES_N; i++) tick(DP_K);
    tick(DP_J);
    if ({suspend_o, resume_o} !== 2'b10) begin
      n_err++;
      $display("FAIL short_k_burst: got %b expected 10", {suspend_o, resume_o});
    end
    n_vec++;
    for (int i = 1; i <= RES_N + 1; i++) begin
      tick(DP_K);
      if (resume_o !== (i == RES_N)) begin
        n_err++;
        $display("FAIL resume_pulse sample %0d: got %b expected %b", i, resume_o, (i == RES_N));
      end
      n_vec++;
      if (suspend_o !== (i < RES_N)) begin
        n_err++;
        $display("FAIL resume_suspend_fall sample %0d: got %b expected %b", i, suspend_o, (i < RES_N));
      end
      n_vec++;
    end
`else
    tick(DP_K);
    if ({suspend_o, resume_o} !== 2'b00) begin
      n_err++;
      $display("FAIL k_wake: got %b expected 00", {suspend_o, resume_o});
    end
    n_vec++;
`endif
  endtask

  task automatic test_suspend_reset;
    int bad;
    for (int i = 0; i < SUS_N; i++) tick(DP_J);
    if (suspend_o !== 1'b1) begin
      n_err++;
      $display("FAIL resuspend: got %b expected 1", suspend_o);
    end
    n_vec++;
    for (int i = 1; i <= RST_N; i++) tick(DP_SE0);
    if ({reset_o, bus_reset_o, suspend_o} !== 3'b110) begin
      n_err++;
      $display("FAIL suspended_reset: got %b expected 110", {reset_o, bus_reset_o, suspend_o});
    end
    n_vec++;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(DP_SE0);
      if (reset_o || suspend_o || !bus_reset_o) bad++;
    end
    if (bad !== 0) begin
      n_err++;
      $display("FAIL long_se0: got %0d bad cycles expected 0", bad);
    end
    n_vec++;
  endtask

  task automatic test_async_reset;
    #2;
    reset_ni = 1'b0;
    #1;
    if ({reset_o, bus_reset_o, suspend_o} !== 3'b000) begin
      n_err++;
      $display("FAIL async_clear: got %b expected 000", {reset_o, bus_reset_o, suspend_o});
    end
    n_vec++;
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    for (int i = 1; i <= RST_N; i++) begin
      tick(DP_SE0);
      if ({reset_o, bus_reset_o} !== ((i == RST_N) ? 2'b11 : 2'b00)) begin
        n_err++;
        $display("FAIL fresh_run sample %0d: got %b expected %b", i, {reset_o, bus_reset_o},
                 ((i == RST_N) ? 2'b11 : 2'b00));
      end
      n_vec++;
    end
    tick(DP_J);
    if ({reset_o, bus_reset_o} !== 2'b00) begin
      n_err++;
      $display("FAIL final_exit: got %b expected 00", {reset_o, bus_reset_o});
    end
    n_vec++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_bus_reset();
    test_se1();
    test_suspend();
    test_resume();
    test_suspend_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
